bounce_generator: RTL and testbench
===================================

# bounce_generator

Synthesizable contact-bounce emulator: the transmitting end of the button-input path. On request it drives a single-bit output from its stable level to a new level through a pseudo-random bounce burst, then holds the new level for a settle window. It sits in the board self-test fabric, and its `btn_output` feeds the debouncer input in place of a physical push-button so that debounce behaviour can be exercised on hardware and in simulation.

## Interface

Parameters:
- `BOUNCE_CYCLES`, default 64: length of the bounce burst in clocks; must be ≥1.
- `SETTLE_CYCLES`, default 2048: clean hold time after the burst; must be ≥1. The default exceeds the 1024-cycle debounce threshold.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero. A value of 0 is replaced by 16'h0001.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: request an event; sampled only in IDLE.
- `target_level` in 1: final level for the event; captured when `start` is accepted.
- `btn_output` out 1: emulated noisy contact, registered.
- `busy` out 1: high while an event is in progress, registered.
- `done` out 1: one-cycle completion pulse, registered.

## Operation

- Reset, on the edge where `reset`=1: state=IDLE, `btn_output`=0, `busy`=0, `done`=0, LFSR=`LFSR_SEED`, counters=0. Reset has priority over everything and aborts an in-progress event; outputs are at their reset values in the next cycle.
- LFSR: 16-bit Galois, right-shift. next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It advances only on BOUNCE-state edges. It keeps its state across events and is reloaded only by reset.
- States:
  - IDLE: `btn_output` holds the last level, `busy`=0.
    - `start`=1 and `target_level`≠`btn_output` → BOUNCE, load the bounce counter with `BOUNCE_CYCLES`.
    - `start`=1 and `target_level`=`btn_output` → SETTLE directly, with no burst and an unchanged level.
    - `target_level` is latched into `tgt_q` in both cases.
  - BOUNCE: each edge, LFSR advances, `btn_output` ← new LFSR bit 0, and the counter decrements. On the edge where the counter reaches 0 → SETTLE, `btn_output` ← `tgt_q`, and the settle counter is loaded with `SETTLE_CYCLES`.
  - SETTLE: `btn_output`=`tgt_q` constant. The counter decrements each edge. On the edge where it reaches 0 → IDLE, `done` ← 1.
- `done` is high for exactly one cycle, the first IDLE cycle. It is cleared on the following edge.
- `start` is ignored while `busy`=1; there is no queueing. `start` asserted in the `done` cycle is accepted.
- Counter widths: $clog2(param+1). No wrap is possible because counters are loaded, not free-running.

## Timing

- `start` is accepted on edge N. `busy`=1 from cycle N+1.
- Level-change event:
  - `btn_output` is LFSR-driven for cycles N+1 … N+B, where B = `BOUNCE_CYCLES`.
  - `btn_output` = `tgt_q` for cycles N+B+1 … N+B+S, where S = `SETTLE_CYCLES`.
  - In cycle N+B+S+1: `busy`=0 and `done`=1.
- Same-level event: `busy`=1 for cycles N+1 … N+S. In cycle N+S+1: `busy`=0 and `done`=1. `btn_output` never toggles.
- Total busy time is exactly B+S cycles for a level-change event and S cycles for a same-level event.
- Zero combinational paths from inputs to outputs.

## Test plan

Bench parameters: B=8, S=16, seed 16'hACE1.

1. Reset held 3 cycles, then released → `btn_output`=0, `busy`=0, `done`=0; no activity without `start`.
2. `start`=1 with `target_level`=1 at edge N →
   - `btn_output` sequence over cycles N+1..N+8 is 0,0,0,0,1,1,1,0.
   - Then 1 for 16 cycles.
   - `done`=1 only at N+25.
   - `busy` is high for exactly 24 cycles.
3. After test 2, `start` with `target_level`=1 → no toggles, `busy` high for 16 cycles, `done` at N+17. A second event with `target_level`=0 continues the LFSR from 16'hC2C4 rather than the seed.
4. `start` pulsed repeatedly during BOUNCE and SETTLE → ignored, timing unchanged. `start` held high in the `done` cycle → a new event begins and `busy` returns high the next cycle.
5. `reset` asserted mid-BOUNCE, and separately mid-SETTLE → next cycle `btn_output`=0, `busy`=0, `done`=0. The LFSR re-seeds, so a rerun reproduces test 2 exactly.
6. Loop the output into the debouncer with S=2048 → the debouncer output reaches `tgt_q` before `done`, with no glitch after settling.

Source files
------------

// File: rtl/bounce_generator_if.sv
// Handshake and output bundle between a bounce_generator and whoever drives it.
interface bounce_generator_if;
    logic start;
    logic target_level;
    logic btn_output;
    logic busy;
    logic done;

    modport master (
        output start,
        output target_level,
        input  btn_output,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  target_level,
        output btn_output,
        output busy,
        output done
    );
endinterface

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: moves btn_output to a requested level through a
// pseudo-random burst, then holds the level clean for a settle window.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | level held, waiting for start
// ST_BOUNCE | btn_output follows LFSR bit 0, counting down the burst
// ST_SETTLE | btn_output = tgt_q, counting down the clean hold window
module bounce_generator #(
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned SETTLE_CYCLES = 2048,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    bounce_generator_if.slave  bus
);

    localparam int unsigned CNT_MAX = (BOUNCE_CYCLES > SETTLE_CYCLES) ? BOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // Counters hold "edges remaining after this one", so each phase lasts
    // exactly its parameter in cycles.
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_SETTLE
    } state_t;

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tgt_q;
    logic             btn_q;
    logic             busy_q;
    logic             done_q;

    // Galois right-shift LFSR step, taps 16'hB400.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Sequencer: state, counter, LFSR and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            btn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        tgt_q  <= bus.target_level;
                        busy_q <= 1'b1;
                        if (bus.target_level != btn_q) begin
                            // First burst value is registered on the accept
                            // edge so the burst fills exactly BOUNCE_CYCLES
                            // output cycles with BOUNCE_CYCLES LFSR steps.
                            lfsr_q  <= lfsr_d;
                            btn_q   <= lfsr_d[0];
                            cnt_q   <= BOUNCE_LOAD;
                            state_q <= ST_BOUNCE;
                        end else begin
                            cnt_q   <= SETTLE_LOAD;
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (cnt_q == '0) begin
                        btn_q   <= tgt_q;
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= ST_SETTLE;
                    end else begin
                        lfsr_q <= lfsr_d;
                        btn_q  <= lfsr_d[0];
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.btn_output = btn_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator (B=8, S=16, seed 16'hACE1).
// Each accepted event pushes its full per-cycle output trace into a
// scoreboard; a negedge monitor pops one entry per cycle and compares.
module tb_bounce_generator;

    localparam int unsigned B    = 8;
    localparam int unsigned S    = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        logic  btn;
        logic  busy;
        logic  done;
        string tag;
    } exp_t;

    logic clk;
    logic reset;
    bounce_generator_if bif ();

    bounce_generator #(
        .BOUNCE_CYCLES(B),
        .SETTLE_CYCLES(S),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    exp_t        sb[$];
    int          npass  = 0;
    int          nfail  = 0;
    int          ntotal = 0;
    logic [15:0] m_lfsr = SEED;
    logic        m_btn  = 1'b0;
    string       cur_tag = "rst";
    logic [7:0]  t2_bits;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string name, input logic obs, input logic exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    // One scoreboard entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".btn"},  bif.btn_output, e.btn);
            check({e.tag, ".busy"}, bif.busy,       e.busy);
            check({e.tag, ".done"}, bif.done,       e.done);
        end
    end

    task automatic push(input logic btn, input logic busy, input logic done);
        exp_t e;
        e.btn  = btn;
        e.busy = busy;
        e.done = done;
        e.tag  = cur_tag;
        sb.push_back(e);
    endtask

    // Trace of one event from the timing rules; include_cur adds the
    // current (still idle) cycle in front.
    task automatic push_event(input logic tgt, input bit include_cur, input bit use_tab);
        if (include_cur) push(m_btn, 1'b0, 1'b0);
        if (tgt != m_btn) begin
            for (int i = 0; i < int'(B); i++) begin
                m_lfsr = lfsr_step(m_lfsr);
                push(use_tab ? t2_bits[i] : m_lfsr[0], 1'b1, 1'b0);
            end
        end
        for (int i = 0; i < int'(S); i++) push(tgt, 1'b1, 1'b0);
        push(tgt, 1'b0, 1'b1);
        m_btn = tgt;
    endtask

    task automatic do_event(input logic tgt, input bit use_tab);
        bif.start        = 1'b1;
        bif.target_level = tgt;
        push_event(tgt, 1'b1, use_tab);
        @(posedge clk); #2;
        bif.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (sb.size() > 0) begin
            ntotal++;
            nfail++;
            $display("FAIL %s.drain_timeout: %0d entries left, expected 0", cur_tag, sb.size());
            sb.delete();
        end
        @(posedge clk); #2;
    endtask

    task automatic wait_done_cycle(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 200) begin
            if (sb.size() == 1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
            n++;
        end
        if (!ok) begin
            ntotal++;
            nfail++;
            $display("FAIL %s.done_wait_timeout: queue %0d, expected 1", cur_tag, sb.size());
        end
    endtask

    // Reset pulse in the current cycle: DUT is at reset values in the next.
    task automatic reset_now();
        while (sb.size() > 1) void'(sb.pop_back());
        reset = 1'b1;
        push(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        reset = 1'b0;
        push(1'b0, 1'b0, 1'b0);
        m_lfsr = SEED;
        m_btn  = 1'b0;
    endtask

    initial begin
        bit ok;
        t2_bits          = 8'b0111_0000;
        reset            = 1'b1;
        bif.start        = 1'b0;
        bif.target_level = 1'b0;

        // 1: reset for 3 cycles, then quiet idle
        repeat (3) @(posedge clk);
        #2;
        reset   = 1'b0;
        cur_tag = "t1_idle";
        for (int i = 0; i < 6; i++) push(1'b0, 1'b0, 1'b0);
        wait_drain();

        // 2: level change 0->1, burst compared against the known sequence
        cur_tag = "t2_rise";
        do_event(1'b1, 1'b1);
        wait_drain();

        // 3: same-level event, then a falling event continuing the LFSR
        cur_tag = "t3_same";
        do_event(1'b1, 1'b0);
        wait_drain();
        cur_tag = "t3_fall";
        do_event(1'b0, 1'b0);
        wait_drain();

        // 4: starts during BOUNCE and SETTLE are ignored; start in done cycle accepted
        cur_tag = "t4_ignore";
        do_event(1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #2; end
        bif.start = 1'b1; bif.target_level = 1'($urandom_range(0, 1));
        @(posedge clk); #2; bif.start = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        bif.start = 1'b1; bif.target_level = 1'b0;
        @(posedge clk); #2; bif.start = 1'b0;
        repeat (6) begin @(posedge clk); #2; end
        bif.start = 1'b1; bif.target_level = 1'b1;
        @(posedge clk); #2; bif.start = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        bif.start = 1'b1; bif.target_level = 1'b0;
        @(posedge clk); #2; bif.start = 1'b0;
        wait_done_cycle(ok);
        if (ok) begin
            cur_tag          = "t4_done_start";
            bif.start        = 1'b1;
            bif.target_level = 1'b0;
            push_event(1'b0, 1'b0, 1'b0);
            @(posedge clk); #2;
            bif.start = 1'b0;
        end
        wait_drain();

        // 5: reset mid-BOUNCE and mid-SETTLE, then a rerun matches test 2
        cur_tag = "t5_bounce";
        do_event(1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #2; end
        cur_tag = "t5_rst_b";
        reset_now();
        wait_drain();
        cur_tag = "t5_settle";
        do_event(1'b1, 1'b0);
        repeat (12) begin @(posedge clk); #2; end
        cur_tag = "t5_rst_s";
        reset_now();
        wait_drain();
        cur_tag = "t5_rerun";
        do_event(1'b1, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
